// File: rtl/mem_sram_hs_if.sv
// Request/response bus between an IFU/LSU master and mem_sram_hs.
// Both channels use valid/ready handshakes.
interface mem_sram_hs_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_wmask;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_sram_hs.sv
// Single-port word memory with valid/ready request and response channels, one transaction in flight.
// Define MEM_RAND_DELAY_EN to add 0..7 LFSR-driven cycles of extra latency per request.
module mem_sram_hs #(
    parameter int                ADDR_W  = 32,
    parameter int                DATA_W  = 32,
    parameter int                DEPTH   = 1024,
    parameter logic [ADDR_W-1:0] BASE    = ADDR_W'(32'h8000_0000),
    parameter int                LATENCY = 2
) (
    input  logic          clock,
    input  logic          reset,
    mem_sram_hs_if.slave  bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                resp_valid_q;
    logic [DATA_W-1:0]   resp_rdata_q;
    logic                resp_err_q;

    logic                we_q;
    logic                in_range_q;
    logic [DATA_W-1:0]   word_q;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic [ADDR_W-1:0]   offset;
    logic [ADDR_W-1:0]   idx;
    logic [IDX_W-1:0]    widx;
    logic                in_range;
    logic                accept;
    logic [CNT_W-1:0]    lat_d;

    // Wrap-around subtraction makes addresses below BASE land far above DEPTH.
    assign offset   = bus.req_addr - BASE;
    assign idx      = offset >> OFF_W;
    assign widx     = idx[IDX_W-1:0];
    assign in_range = idx < ADDR_W'(DEPTH);

    assign bus.req_ready = (state_q == IDLE) && !reset;
    assign accept        = bus.req_valid && bus.req_ready;

`ifdef MEM_RAND_DELAY_EN
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // x^8 + x^6 + x^5 + x^4 + 1, shifting towards the MSB.
    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lat_d = CNT_W'(LATENCY) + CNT_W'(lfsr_q[2:0]);
`else
    assign lat_d = CNT_W'(LATENCY);
`endif

    // NOTE: storage and per-transaction captures carry no reset; only control state does.
    always_ff @(posedge clock) begin
        if (accept && bus.req_we && in_range) begin
            for (int b = 0; b < BYTES; b++) begin
                if (bus.req_wmask[b]) begin
                    mem_q[widx][b*8 +: 8] <= bus.req_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            we_q       <= bus.req_we;
            in_range_q <= in_range;
            word_q     <= mem_q[widx];
        end
    end

    // resp_valid is registered on the first RESP cycle, so it rises LATENCY edges after acceptance.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cnt_q   <= lat_d - CNT_W'(1);
                        state_q <= (lat_d == CNT_W'(1)) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (!resp_valid_q) begin
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= (in_range_q && !we_q) ? word_q : '0;
                        resp_err_q   <= !in_range_q;
                    end else if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= '0;
                        resp_err_q   <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_mem_sram_hs.sv
// Scoreboard bench for mem_sram_hs: the driver queues expected responses, a monitor pops and compares.
module tb_mem_sram_hs;
    localparam int LAT = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    bit   prev_valid = 1'b0;
    int   first_cyc = 0;
    exp_t e;

    mem_sram_hs_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    mem_sram_hs #(.LATENCY(LAT)) dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge; returns at the negedge after acceptance with req_valid dropped.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wmask, input logic [31:0] exp_rdata,
                          input logic exp_err, input bit expect_resp);
        int n = 0;
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = we;
        bus_if.req_addr  = addr;
        bus_if.req_wdata = wdata;
        bus_if.req_wmask = wmask;
        while (!bus_if.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus_if.req_ready) check("req_accept_timeout", 32'(bus_if.req_ready), 1);
        if (expect_resp) sb.push_back('{rdata: exp_rdata, err: exp_err, acc: cyc + 1});
        @(negedge clk);
        bus_if.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_queue", 32'(sb.size()), 0);
    endtask

    // Monitor samples just after the falling edge so driver updates at that edge are visible.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (bus_if.resp_valid && !prev_valid) first_cyc = cyc;
            prev_valid = bus_if.resp_valid;
            if (bus_if.resp_valid && bus_if.resp_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 32'(bus_if.resp_valid), 0);
                end else begin
                    e = sb.pop_front();
                    check("resp_rdata", bus_if.resp_rdata, e.rdata);
                    check("resp_err", 32'(bus_if.resp_err), 32'(e.err));
`ifdef MEM_RAND_DELAY_EN
                    check("latency_in_range",
                          32'((first_cyc - e.acc >= LAT) && (first_cyc - e.acc <= LAT + 7)), 1);
`else
                    check("latency", 32'(first_cyc - e.acc), LAT);
`endif
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bus_if.req_valid  = 1'b0;
        bus_if.req_we     = 1'b0;
        bus_if.req_addr   = '0;
        bus_if.req_wdata  = '0;
        bus_if.req_wmask  = '0;
        bus_if.resp_ready = 1'b1;
        reset = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(bus_if.req_ready), 0);
        check("rst_resp_valid", 32'(bus_if.resp_valid), 0);
        check("rst_resp_rdata", bus_if.resp_rdata, 0);
        check("rst_resp_err", 32'(bus_if.resp_err), 0);
        reset = 1'b0;
        #1;
        check("post_rst_req_ready", 32'(bus_if.req_ready), 1);
        @(negedge clk);

        // Full-word write then read, including an unaligned address in the same word.
        do_req(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 1'b1);
        do_req(1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        do_req(1'b0, 32'h8000_0013, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        wait_idle();

        // Byte mask and empty mask.
        do_req(1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 32'h0, 1'b0, 1'b1);
        do_req(1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0, 1'b1);
        do_req(1'b0, 32'h8000_0020, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0, 1'b1);
        do_req(1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, 1'b1);
        do_req(1'b0, 32'h8000_0020, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0, 1'b1);
        wait_idle();

        // Range boundaries; the out-of-range write would alias word 0 if not blocked.
        do_req(1'b1, 32'h8000_0000, 32'h0102_0304, 4'hF, 32'h0, 1'b0, 1'b1);
        do_req(1'b1, 32'h8000_0FFC, 32'h5A5A_5A5A, 4'hF, 32'h0, 1'b0, 1'b1);
        do_req(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
        do_req(1'b0, 32'h8000_1000, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
        do_req(1'b1, 32'h8000_1000, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b1, 1'b1);
        do_req(1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'h0102_0304, 1'b0, 1'b1);
        do_req(1'b0, 32'h8000_0FFC, 32'h0, 4'h0, 32'h5A5A_5A5A, 1'b0, 1'b1);
        wait_idle();

        // Response backpressure: outputs hold for 5 cycles while resp_ready is low.
        bus_if.resp_ready = 1'b0;
        do_req(1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        n = 0;
        while (!bus_if.resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("stall_resp_valid", 32'(bus_if.resp_valid), 1);
            check("stall_resp_rdata", bus_if.resp_rdata, 32'hDEAD_BEEF);
            check("stall_resp_err", 32'(bus_if.resp_err), 0);
            check("stall_req_ready", 32'(bus_if.req_ready), 0);
            @(negedge clk);
        end
        bus_if.resp_ready = 1'b1;
        @(negedge clk);
        check("after_hs_resp_valid", 32'(bus_if.resp_valid), 0);
        check("after_hs_req_ready", 32'(bus_if.req_ready), 1);
        wait_idle();

        // Reset while waiting aborts the read with no response.
        do_req(1'b0, 32'h8000_0020, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_req_ready_in_reset", 32'(bus_if.req_ready), 0);
        check("abort_resp_valid_in_reset", 32'(bus_if.resp_valid), 0);
        reset = 1'b0;
        #1;
        check("abort_req_ready_after", 32'(bus_if.req_ready), 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_resp", 32'(bus_if.resp_valid), 0);
        end
        do_req(1'b0, 32'h8000_0020, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0, 1'b1);
        wait_idle();

        // Back-to-back reads over a small table of known words.
        for (int i = 0; i < 8; i++) begin
            do_req(1'b1, 32'h8000_0100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i * 32'h0101), 4'hF,
                   32'h0, 1'b0, 1'b1);
        end
        for (int i = 0; i < 100; i++) begin
            do_req(1'b0, 32'h8000_0100 + 32'(4 * (i % 8)), 32'h0, 4'h0,
                   32'hC0DE_0000 + 32'((i % 8) * 32'h0101), 1'b0, 1'b1);
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
